andla_sdma: RTL and testbench

- Store-DMA engine: the write-back counterpart of the LDMA load path. It moves a 4-D tensor from shared RAM (SHRAM) to external RAM (EXRAM).
- SHRAM is read linearly with a fixed read latency. EXRAM writes are issued on a valid/ready channel using per-dimension byte strides.
- Sits beside the LDMA under the same register-file control. Reports done, exception and a running checksum back to the register file.

---
 rtl/andla_sdma_pkg.sv | 23 ++
 rtl/andla_sdma_fifo.sv | 76 +++++++
 rtl/andla_sdma.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_andla_sdma.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/andla_sdma_pkg.sv
// andla_sdma_pkg: types and constants shared by the store-DMA engine.
//   sdma_state_e      : control FSM states
//   SDMA_BEAT_BYTES   : EXRAM byte increment per beat
//   sdma_fifo_entry_t : one buffered write {byte address, beat data}
package andla_sdma_pkg;

  localparam int unsigned SDMA_EXRAM_ADDR_BW = 32;
  localparam int unsigned SDMA_DATA_BW       = 64;
  localparam int unsigned SDMA_BEAT_BYTES    = SDMA_DATA_BW / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sdma_state_e;

  typedef struct packed {
    logic [SDMA_EXRAM_ADDR_BW-1:0] addr;
    logic [SDMA_DATA_BW-1:0]       data;
  } sdma_fifo_entry_t;

endpackage

// File: rtl/andla_sdma_fifo.sv
// andla_sdma_fifo: synchronous FIFO with occupancy count.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write side (ignored when full unless popping in the same cycle)
//   pop, pop_data   : read side, pop_data is the current head (ignored when empty)
//   count           : number of stored entries (0..DEPTH)
module andla_sdma_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    pop_data = mem_q[rd_ptr_q];
    count    = count_q;
  end

endmodule

// File: rtl/andla_sdma.sv
// andla_sdma: store-DMA engine, copies a 4-D tensor from SHRAM to EXRAM.
//   clk, rst_n             : clock, synchronous ACTIVE-HIGH reset (rst_n=1 resets)
//   rf_sdma_*              : start pulse, base addresses, c/w/h/n counts, byte strides
//   shram_rd_*             : linear SHRAM reads, data returns SHRAM_RD_LAT cycles later
//   exram_wr_*             : valid/ready write channel fed from the write-data FIFO
//   rf_sdma_busy/done/except_trigger/chsum_data : status back to the register file
module andla_sdma
  import andla_sdma_pkg::*;
#(
  parameter int unsigned EXRAM_ADDR_BW = 32,
  parameter int unsigned SHRAM_ADDR_BW = 16,
  parameter int unsigned DIM_BW        = 16,
  parameter int unsigned STRIDE_BW     = 32,
  parameter int unsigned DATA_BW       = 64,
  parameter int unsigned SHRAM_RD_LAT  = 2,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rf_sdma_start,
  input  logic [EXRAM_ADDR_BW-1:0] rf_sdma_exram_addr,
  input  logic [SHRAM_ADDR_BW-1:0] rf_sdma_shram_addr,
  input  logic [DIM_BW-1:0]        rf_sdma_c,
  input  logic [DIM_BW-1:0]        rf_sdma_w,
  input  logic [DIM_BW-1:0]        rf_sdma_h,
  input  logic [DIM_BW-1:0]        rf_sdma_n,
  input  logic [STRIDE_BW-1:0]     rf_sdma_exram_stride_w_size,
  input  logic [STRIDE_BW-1:0]     rf_sdma_exram_stride_h_size,
  input  logic [STRIDE_BW-1:0]     rf_sdma_exram_stride_n_size,
  output logic                     shram_rd_en,
  output logic [SHRAM_ADDR_BW-1:0] shram_rd_addr,
  input  logic [DATA_BW-1:0]       shram_rd_data,
  output logic                     exram_wr_valid,
  input  logic                     exram_wr_ready,
  output logic [EXRAM_ADDR_BW-1:0] exram_wr_addr,
  output logic [DATA_BW-1:0]       exram_wr_data,
  output logic                     rf_sdma_busy,
  output logic                     rf_sdma_done,
  output logic                     rf_sdma_except_trigger,
  output logic [31:0]              rf_sdma_chsum_data
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WORDS = DATA_BW / 32;

  sdma_state_e state_q, state_d;

  logic [EXRAM_ADDR_BW-1:0] exram_base_q, exram_base_d;
  logic [DIM_BW-1:0]        c_q, c_d, w_q, w_d, h_q, h_d, n_q, n_d;
  logic [EXRAM_ADDR_BW-1:0] stride_w_q, stride_w_d;
  logic [EXRAM_ADDR_BW-1:0] stride_h_q, stride_h_d;
  logic [EXRAM_ADDR_BW-1:0] stride_n_q, stride_n_d;
  logic [DIM_BW-1:0]        ci_q, ci_d, wi_q, wi_d, hi_q, hi_d, ni_q, ni_d;
  logic [EXRAM_ADDR_BW-1:0] off_c_q, off_c_d, off_w_q, off_w_d;
  logic [EXRAM_ADDR_BW-1:0] off_h_q, off_h_d, off_n_q, off_n_d;
  logic [SHRAM_ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         inflight_q, inflight_d;
  logic [SHRAM_RD_LAT-1:0]  pipe_vld_q, pipe_vld_d;
  logic [EXRAM_ADDR_BW-1:0] pipe_addr_q [SHRAM_RD_LAT];
  logic [EXRAM_ADDR_BW-1:0] pipe_addr_d [SHRAM_RD_LAT];
  logic [31:0]              chsum_q, chsum_d;
  logic                     except_q, except_d;

  logic                     zero_dim, credit_ok, rd_fire, last_tuple;
  logic                     last_c, last_w, last_h, last_n;
  logic [EXRAM_ADDR_BW-1:0] issue_addr;
  logic [31:0]              beat_sum;

  logic                     fifo_push, fifo_pop;
  logic [CNT_W-1:0]         fifo_count;
  sdma_fifo_entry_t         fifo_in, fifo_head;

  andla_sdma_fifo #(
    .WIDTH ($bits(sdma_fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    zero_dim   = (rf_sdma_c == '0) || (rf_sdma_w == '0) ||
                 (rf_sdma_h == '0) || (rf_sdma_n == '0);
    // Reads already in flight have a reserved FIFO slot, so counting them
    // as occupied keeps the FIFO from ever overflowing.
    credit_ok  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH);
    rd_fire    = (state_q == S_RUN) && credit_ok;
    last_c     = (ci_q == c_q - DIM_BW'(1));
    last_w     = (wi_q == w_q - DIM_BW'(1));
    last_h     = (hi_q == h_q - DIM_BW'(1));
    last_n     = (ni_q == n_q - DIM_BW'(1));
    last_tuple = last_c && last_w && last_h && last_n;
    issue_addr = exram_base_q + off_c_q + off_w_q + off_h_q + off_n_q;

    fifo_push     = pipe_vld_q[SHRAM_RD_LAT-1];
    fifo_in.addr  = pipe_addr_q[SHRAM_RD_LAT-1];
    fifo_in.data  = shram_rd_data;
    exram_wr_valid = (fifo_count != '0);
    fifo_pop      = exram_wr_valid && exram_wr_ready;

    beat_sum = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      beat_sum = beat_sum + fifo_head.data[i*32 +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    exram_base_d = exram_base_q;
    c_d          = c_q;
    w_d          = w_q;
    h_d          = h_q;
    n_d          = n_q;
    stride_w_d   = stride_w_q;
    stride_h_d   = stride_h_q;
    stride_n_d   = stride_n_q;
    ci_d         = ci_q;
    wi_d         = wi_q;
    hi_d         = hi_q;
    ni_d         = ni_q;
    off_c_d      = off_c_q;
    off_w_d      = off_w_q;
    off_h_d      = off_h_q;
    off_n_d      = off_n_q;
    rd_ptr_d     = rd_ptr_q;
    chsum_d      = chsum_q;
    except_d     = 1'b0;

    pipe_vld_d[0]  = rd_fire;
    pipe_addr_d[0] = issue_addr;
    for (int unsigned i = 1; i < SHRAM_RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    inflight_d = inflight_q;
    if (rd_fire && !fifo_push) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (fifo_push && !rd_fire) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    if (fifo_pop) begin
      chsum_d = chsum_q + beat_sum;
    end

    // Odometer over (c, w, h, n); offsets are running sums so no multiplier.
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + SHRAM_ADDR_BW'(1);
      if (!last_c) begin
        ci_d    = ci_q + DIM_BW'(1);
        off_c_d = off_c_q + EXRAM_ADDR_BW'(SDMA_BEAT_BYTES);
      end else begin
        ci_d    = '0;
        off_c_d = '0;
        if (!last_w) begin
          wi_d    = wi_q + DIM_BW'(1);
          off_w_d = off_w_q + stride_w_q;
        end else begin
          wi_d    = '0;
          off_w_d = '0;
          if (!last_h) begin
            hi_d    = hi_q + DIM_BW'(1);
            off_h_d = off_h_q + stride_h_q;
          end else begin
            hi_d    = '0;
            off_h_d = '0;
            if (!last_n) begin
              ni_d    = ni_q + DIM_BW'(1);
              off_n_d = off_n_q + stride_n_q;
            end
          end
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (rf_sdma_start) begin
          if (zero_dim) begin
            except_d = 1'b1;
          end else begin
            exram_base_d = rf_sdma_exram_addr;
            c_d          = rf_sdma_c;
            w_d          = rf_sdma_w;
            h_d          = rf_sdma_h;
            n_d          = rf_sdma_n;
            stride_w_d   = EXRAM_ADDR_BW'(rf_sdma_exram_stride_w_size);
            stride_h_d   = EXRAM_ADDR_BW'(rf_sdma_exram_stride_h_size);
            stride_n_d   = EXRAM_ADDR_BW'(rf_sdma_exram_stride_n_size);
            ci_d         = '0;
            wi_d         = '0;
            hi_d         = '0;
            ni_d         = '0;
            off_c_d      = '0;
            off_w_d      = '0;
            off_h_d      = '0;
            off_n_d      = '0;
            rd_ptr_d     = rf_sdma_shram_addr;
            chsum_d      = '0;
            state_d      = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rd_fire && last_tuple) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave on the final handshake itself so done lands the next cycle.
        if ((inflight_q == '0) &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      exram_base_q <= '0;
      c_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      n_q          <= '0;
      stride_w_q   <= '0;
      stride_h_q   <= '0;
      stride_n_q   <= '0;
      ci_q         <= '0;
      wi_q         <= '0;
      hi_q         <= '0;
      ni_q         <= '0;
      off_c_q      <= '0;
      off_w_q      <= '0;
      off_h_q      <= '0;
      off_n_q      <= '0;
      rd_ptr_q     <= '0;
      inflight_q   <= '0;
      pipe_vld_q   <= '0;
      chsum_q      <= '0;
      except_q     <= 1'b0;
      for (int unsigned i = 0; i < SHRAM_RD_LAT; i++) begin
        pipe_addr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      exram_base_q <= exram_base_d;
      c_q          <= c_d;
      w_q          <= w_d;
      h_q          <= h_d;
      n_q          <= n_d;
      stride_w_q   <= stride_w_d;
      stride_h_q   <= stride_h_d;
      stride_n_q   <= stride_n_d;
      ci_q         <= ci_d;
      wi_q         <= wi_d;
      hi_q         <= hi_d;
      ni_q         <= ni_d;
      off_c_q      <= off_c_d;
      off_w_q      <= off_w_d;
      off_h_q      <= off_h_d;
      off_n_q      <= off_n_d;
      rd_ptr_q     <= rd_ptr_d;
      inflight_q   <= inflight_d;
      pipe_vld_q   <= pipe_vld_d;
      chsum_q      <= chsum_d;
      except_q     <= except_d;
      for (int unsigned i = 0; i < SHRAM_RD_LAT; i++) begin
        pipe_addr_q[i] <= pipe_addr_d[i];
      end
    end
  end

  always_comb begin
    shram_rd_en            = rd_fire;
    shram_rd_addr          = rd_ptr_q;
    exram_wr_addr          = exram_wr_valid ? fifo_head.addr : '0;
    exram_wr_data          = exram_wr_valid ? fifo_head.data : '0;
    rf_sdma_busy           = (state_q != S_IDLE);
    rf_sdma_done           = (state_q == S_DONE);
    rf_sdma_except_trigger = except_q;
    rf_sdma_chsum_data     = chsum_q;
  end

endmodule

// File: tb/tb_andla_sdma.sv
module tb_andla_sdma;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        rf_sdma_start;
  logic [31:0] rf_sdma_exram_addr;
  logic [15:0] rf_sdma_shram_addr;
  logic [15:0] rf_sdma_c, rf_sdma_w, rf_sdma_h, rf_sdma_n;
  logic [31:0] rf_sdma_exram_stride_w_size;
  logic [31:0] rf_sdma_exram_stride_h_size;
  logic [31:0] rf_sdma_exram_stride_n_size;
  logic        shram_rd_en;
  logic [15:0] shram_rd_addr;
  logic [63:0] shram_rd_data;
  logic        exram_wr_valid;
  logic        exram_wr_ready;
  logic [31:0] exram_wr_addr;
  logic [63:0] exram_wr_data;
  logic        rf_sdma_busy;
  logic        rf_sdma_done;
  logic        rf_sdma_except_trigger;
  logic [31:0] rf_sdma_chsum_data;

  andla_sdma #(
    .EXRAM_ADDR_BW (32),
    .SHRAM_ADDR_BW (16),
    .DIM_BW        (16),
    .STRIDE_BW     (32),
    .DATA_BW       (64),
    .SHRAM_RD_LAT  (LAT),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .rf_sdma_start               (rf_sdma_start),
    .rf_sdma_exram_addr          (rf_sdma_exram_addr),
    .rf_sdma_shram_addr          (rf_sdma_shram_addr),
    .rf_sdma_c                   (rf_sdma_c),
    .rf_sdma_w                   (rf_sdma_w),
    .rf_sdma_h                   (rf_sdma_h),
    .rf_sdma_n                   (rf_sdma_n),
    .rf_sdma_exram_stride_w_size (rf_sdma_exram_stride_w_size),
    .rf_sdma_exram_stride_h_size (rf_sdma_exram_stride_h_size),
    .rf_sdma_exram_stride_n_size (rf_sdma_exram_stride_n_size),
    .shram_rd_en                 (shram_rd_en),
    .shram_rd_addr               (shram_rd_addr),
    .shram_rd_data               (shram_rd_data),
    .exram_wr_valid              (exram_wr_valid),
    .exram_wr_ready              (exram_wr_ready),
    .exram_wr_addr               (exram_wr_addr),
    .exram_wr_data               (exram_wr_data),
    .rf_sdma_busy                (rf_sdma_busy),
    .rf_sdma_done                (rf_sdma_done),
    .rf_sdma_except_trigger      (rf_sdma_except_trigger),
    .rf_sdma_chsum_data          (rf_sdma_chsum_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Beat content stored at a SHRAM word address.
  int unsigned data_mode  = 0;
  int unsigned ready_mode = 0;

  function automatic logic [63:0] data_of(input logic [15:0] a, input int unsigned m);
    logic [31:0] x;
    x = {16'h0, a};
    if (m == 0) return {32'h0, x};
    return {x * 32'h9E37_79B1, x ^ 32'hC0DE_0000};
  endfunction

  // SHRAM: data for a read appears exactly LAT cycles after its rd_en.
  logic        hist_vld  [LAT];
  logic [15:0] hist_addr [LAT];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist_vld[0]  <= shram_rd_en;
    hist_addr[0] <= shram_rd_addr;
    for (int i = 1; i < LAT; i++) begin
      hist_vld[i]  <= hist_vld[i-1];
      hist_addr[i] <= hist_addr[i-1];
    end
  end

  assign shram_rd_data = (hist_vld[LAT-1] === 1'b1) ? data_of(hist_addr[LAT-1], data_mode)
                                                    : 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    exram_wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       exram_wr_ready = 1'b1;
        1:       exram_wr_ready = ((cyc % 4) == 0);
        default: exram_wr_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Reference model: expected write stream, SHRAM read order, checksum.
  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_data_q [$];
  logic [15:0] exp_rd_q   [$];
  logic [31:0] model_chsum;

  task automatic build_model(input int unsigned c, w, h, n, input logic [31:0] exb,
                             input logic [15:0] shb, input logic [31:0] sw, sh, sn,
                             input int unsigned dm, output logic [31:0] last_a);
    logic [15:0] sa;
    logic [31:0] a;
    logic [63:0] d;
    int unsigned lin;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_rd_q.delete();
    model_chsum = 32'h0;
    last_a = 32'h0;
    lin = 0;
    for (int unsigned ni = 0; ni < n; ni++)
      for (int unsigned hi = 0; hi < h; hi++)
        for (int unsigned wi = 0; wi < w; wi++)
          for (int unsigned ci = 0; ci < c; ci++) begin
            sa = shb + 16'(lin);
            a  = exb + 32'(ci) * 32'd8 + 32'(wi) * sw + 32'(hi) * sh + 32'(ni) * sn;
            d  = data_of(sa, dm);
            exp_rd_q.push_back(sa);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(d);
            model_chsum = model_chsum + d[31:0] + d[63:32];
            last_a = a;
            lin++;
          end
  endtask

  // Monitor: compares every read and every write handshake to the model.
  int          hs_count    = 0;
  int          rd_count    = 0;
  int          done_count  = 0;
  int          last_hs_cyc = -10;
  logic [31:0] last_addr   = 32'h0;

  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [63:0] prev_data;
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    prev_data  = 64'h0;
    forever begin
      @(negedge clk);
      if (shram_rd_en === 1'b1) begin
        rd_count++;
        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
        else check("shram_rd_addr", 64'(shram_rd_addr), 64'(exp_rd_q.pop_front()));
      end
      if (prev_stall) begin
        check("stall_valid_addr", {31'h0, exram_wr_valid, exram_wr_addr}, {32'h1, prev_addr});
        check("stall_data", exram_wr_data, prev_data);
      end
      prev_stall = (exram_wr_valid === 1'b1) && (exram_wr_ready === 1'b0) && (rst_n === 1'b0);
      prev_addr  = exram_wr_addr;
      prev_data  = exram_wr_data;
      if ((exram_wr_valid === 1'b1) && (exram_wr_ready === 1'b1)) begin
        hs_count++;
        last_hs_cyc = cyc;
        last_addr   = exram_wr_addr;
        if (exp_addr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else begin
          check("wr_addr", 64'(exram_wr_addr), 64'(exp_addr_q.pop_front()));
          check("wr_data", exram_wr_data, exp_data_q.pop_front());
        end
      end
      if (rf_sdma_done === 1'b1) begin
        done_count++;
        check("done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
        check("done_beats_left", 64'(exp_addr_q.size()), 64'd0);
      end
    end
  end

  task automatic set_fields(input int unsigned c, w, h, n, input logic [31:0] exb,
                            input logic [15:0] shb, input logic [31:0] sw, sh, sn);
    rf_sdma_c = 16'(c);
    rf_sdma_w = 16'(w);
    rf_sdma_h = 16'(h);
    rf_sdma_n = 16'(n);
    rf_sdma_exram_addr = exb;
    rf_sdma_shram_addr = shb;
    rf_sdma_exram_stride_w_size = sw;
    rf_sdma_exram_stride_h_size = sh;
    rf_sdma_exram_stride_n_size = sn;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 rf_sdma_start = 1'b1;
    @(posedge clk);
    #1 rf_sdma_start = 1'b0;
  endtask

  task automatic run_xfer(input int unsigned c, w, h, n, input logic [31:0] exb,
                          input logic [15:0] shb, input logic [31:0] sw, sh, sn,
                          input int unsigned rm, dm, exp_beats, input logic [31:0] exp_last,
                          input bit has_chsum, input logic [31:0] exp_chsum);
    logic [31:0] model_last;
    int          h0;
    int          t;
    build_model(c, w, h, n, exb, shb, sw, sh, sn, dm, model_last);
    set_fields(c, w, h, n, exb, shb, sw, sh, sn);
    ready_mode = rm;
    data_mode  = dm;
    h0 = hs_count;
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 64'(rf_sdma_busy), 64'd1);
    t = 0;
    while (rf_sdma_done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("done_timeout", 64'd1, 64'd0);
    check("beats", 64'(hs_count - h0), 64'(exp_beats));
    check("last_addr", 64'(last_addr), 64'(exp_last));
    check("chsum", 64'(rf_sdma_chsum_data), 64'(model_chsum));
    if (has_chsum) check("chsum_const", 64'(rf_sdma_chsum_data), 64'(exp_chsum));
    @(negedge clk);
    check("busy_idle", 64'(rf_sdma_busy), 64'd0);
    repeat (2) @(negedge clk);
    check("chsum_hold", 64'(rf_sdma_chsum_data), 64'(model_chsum));
  endtask

  typedef struct {
    int unsigned c, w, h, n;
    logic [31:0] exb;
    logic [15:0] shb;
    logic [31:0] sw, sh, sn;
    int unsigned rmode, dmode, exp_beats;
    logic [31:0] exp_last;
    bit          has_chsum;
    logic [31:0] exp_chsum;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int h0, r0, d0, t;
    vecs[0] = '{4, 1, 1, 1, 32'h0000_1000, 16'h0010, 32'h0, 32'h0, 32'h0, 0, 0, 4,
                32'h0000_1018, 1'b1, 32'h46};
    vecs[1] = '{2, 3, 2, 2, 32'h0001_0000, 16'h0100, 32'h40, 32'h200, 32'h1000, 0, 1, 24,
                32'h0001_1288, 1'b0, 32'h0};
    vecs[2] = '{16, 1, 1, 1, 32'h0000_8000, 16'hFFF8, 32'h0, 32'h0, 32'h0, 1, 1, 16,
                32'h0000_8078, 1'b0, 32'h0};
    vecs[3] = '{2, 1, 1, 1, 32'hFFFF_FFF8, 16'h0020, 32'h0, 32'h0, 32'h0, 0, 0, 2,
                32'h0000_0000, 1'b1, 32'h41};

    rf_sdma_start = 1'b0;
    set_fields(1, 1, 1, 1, 32'h0, 16'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(rf_sdma_busy), 64'd0);
    check("rst_valid_rd", {62'h0, exram_wr_valid, shram_rd_en}, 64'd0);
    check("rst_chsum", 64'(rf_sdma_chsum_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i].c, vecs[i].w, vecs[i].h, vecs[i].n, vecs[i].exb, vecs[i].shb,
               vecs[i].sw, vecs[i].sh, vecs[i].sn, vecs[i].rmode, vecs[i].dmode,
               vecs[i].exp_beats, vecs[i].exp_last, vecs[i].has_chsum, vecs[i].exp_chsum);
    end

    // Zero dimension: exception pulse only.
    exp_rd_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    set_fields(4, 2, 0, 1, 32'h3000, 16'h0, 32'h40, 32'h0, 32'h0);
    r0 = rd_count;
    d0 = done_count;
    pulse_start();
    @(negedge clk);
    check("except_pulse", 64'(rf_sdma_except_trigger), 64'd1);
    check("except_busy", 64'(rf_sdma_busy), 64'd0);
    @(negedge clk);
    check("except_one_cycle", 64'(rf_sdma_except_trigger), 64'd0);
    repeat (8) @(negedge clk);
    check("except_no_reads", 64'(rd_count - r0), 64'd0);
    check("except_no_done", 64'(done_count - d0), 64'd0);
    check("except_busy_late", 64'(rf_sdma_busy), 64'd0);

    // Start while busy is ignored; reset mid-transfer aborts.
    begin
      logic [31:0] la;
      build_model(8, 1, 1, 1, 32'h2000, 16'h0040, 32'h0, 32'h0, 32'h0, 1, la);
      set_fields(8, 1, 1, 1, 32'h2000, 16'h0040, 32'h0, 32'h0, 32'h0);
      ready_mode = 0;
      data_mode  = 1;
      h0 = hs_count;
      pulse_start();
      t = 0;
      while ((hs_count - h0) < 1 && t < 200) begin @(negedge clk); t++; end
      set_fields(3, 1, 1, 1, 32'h9000, 16'h0500, 32'h0, 32'h0, 32'h0);
      pulse_start();
      @(negedge clk);
      check("busy_start_no_except", 64'(rf_sdma_except_trigger), 64'd0);
      while ((hs_count - h0) < 3 && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) check("abort_wait_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_rd_q.delete();
      exp_addr_q.delete();
      exp_data_q.delete();
      @(negedge clk);
      check("abort_outputs", {58'h0, rf_sdma_busy, rf_sdma_done, rf_sdma_except_trigger,
                              shram_rd_en, exram_wr_valid, 1'b0}, 64'd0);
      check("abort_addr_chsum", {exram_wr_addr, rf_sdma_chsum_data}, 64'd0);
      check("abort_data", exram_wr_data, 64'd0);
      h0 = hs_count;
      r0 = rd_count;
      d0 = done_count;
      repeat (8) @(negedge clk);
      check("abort_quiet", 64'((hs_count - h0) + (rd_count - r0) + (done_count - d0)), 64'd0);
    end
    run_xfer(8, 1, 1, 1, 32'h2000, 16'h0040, 32'h0, 32'h0, 32'h0, 0, 1, 8,
             32'h0000_2038, 1'b0, 32'h0);

    // Randomized shapes, bases, strides and backpressure.
    for (int k = 0; k < 6; k++) begin
      int unsigned c, w, h, n;
      logic [31:0] exb, sw, sh, sn, la;
      logic [15:0] shb;
      c   = $urandom_range(1, 6);
      w   = $urandom_range(1, 3);
      h   = $urandom_range(1, 3);
      n   = $urandom_range(1, 3);
      exb = $urandom;
      shb = 16'($urandom);
      sw  = $urandom;
      sh  = $urandom;
      sn  = $urandom;
      build_model(c, w, h, n, exb, shb, sw, sh, sn, 1, la);
      run_xfer(c, w, h, n, exb, shb, sw, sh, sn, 2, 1, c * w * h * n, la, 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
